// File: rtl/bus_arbiter.sv
// bus_arbiter: owner of the shared 8-bit address / 32-bit data bus.
// Arbitrates between the processor and the DMA engine (instruction, I/O1
// interrupt, I/O2 interrupt). Ownership changes go through a one-cycle
// TURN dead cycle, DMA bursts are count-driven, and processor ownership
// is bounded while DMA-side work is waiting. All outputs are registered.
module bus_arbiter #(
    parameter int unsigned MAX_CPU_HOLD = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       dma_req,
    input  logic [5:0] dma_count,
    input  logic       IOIP1,
    input  logic       IOIP2,
    output logic       cpu_grant,
    output logic       grant,
    output logic       busybus,
    output logic [1:0] io_sel,
    output logic [6:0] dma_remaining,
    output logic       dma_done
);

    // Controller states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CPU  = 2'd1;
    localparam logic [1:0] ST_DMA  = 2'd2;
    localparam logic [1:0] ST_TURN = 2'd3;

    // Owner selected for the cycle after TURN
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    // DMA grant reasons reported on io_sel
    localparam logic [1:0] SEL_INSTR = 2'b00;
    localparam logic [1:0] SEL_IO1   = 2'b01;
    localparam logic [1:0] SEL_IO2   = 2'b10;

    // Preemption fires on the edge where hold_cnt would step up to MAX_CPU_HOLD
    localparam logic [7:0] HOLD_LAST = 8'(MAX_CPU_HOLD - 1);

    // Registered state
    logic [1:0] state;
    logic       next_owner;
    logic [7:0] hold_cnt;

    // Next-cycle values
    logic [1:0] state_nxt;
    logic       next_owner_nxt;
    logic [7:0] hold_cnt_nxt;
    logic [6:0] remaining_nxt;
    logic [1:0] io_sel_nxt;
    logic       done_nxt;

    // Arbitration helpers
    logic       dma_any;
    logic [1:0] win_sel;
    logic [6:0] win_len;
    logic       start_dma;
    logic       start_cpu;

    // DMA-side winner: instruction beats I/O1 beats I/O2; zero count means one word
    always_comb begin
        dma_any = dma_req | IOIP1 | IOIP2;
        if (dma_req) begin
            win_sel = SEL_INSTR;
            win_len = (dma_count == 6'd0) ? 7'd1 : {1'b0, dma_count};
        end else if (IOIP1) begin
            win_sel = SEL_IO1;
            win_len = 7'd1;
        end else begin
            win_sel = SEL_IO2;
            win_len = 7'd1;
        end
    end

    // Ownership sequencing: decide where the bus goes at the next edge
    always_comb begin
        state_nxt      = state;
        next_owner_nxt = next_owner;
        hold_cnt_nxt   = '0;
        remaining_nxt  = dma_remaining;
        done_nxt       = 1'b0;
        start_dma      = 1'b0;
        start_cpu      = 1'b0;

        case (state)
            ST_IDLE: begin
                // DMA-side work wins from IDLE and skips the dead cycle
                if (dma_any) begin
                    start_dma = 1'b1;
                end else if (cpu_req) begin
                    start_cpu = 1'b1;
                end
            end

            ST_CPU: begin
                hold_cnt_nxt = dma_any ? hold_cnt + 8'd1 : '0;
                if (!cpu_req) begin
                    hold_cnt_nxt = '0;
                    if (dma_any) begin
                        state_nxt      = ST_TURN;
                        next_owner_nxt = OWN_DMA;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (dma_any && (hold_cnt == HOLD_LAST)) begin
                    hold_cnt_nxt   = '0;
                    state_nxt      = ST_TURN;
                    next_owner_nxt = OWN_DMA;
                end
            end

            ST_DMA: begin
                // Burst length is fixed at entry; requests cannot shorten or preempt it
                if (dma_remaining == 7'd1) begin
                    remaining_nxt = '0;
                    done_nxt      = 1'b1;
                    if (cpu_req) begin
                        state_nxt      = ST_TURN;
                        next_owner_nxt = OWN_CPU;
                    end else if (dma_any) begin
                        state_nxt      = ST_TURN;
                        next_owner_nxt = OWN_DMA;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    remaining_nxt = dma_remaining - 7'd1;
                end
            end

            ST_TURN: begin
                // Target is re-checked against live requests; fall back to the other side
                state_nxt = ST_IDLE;
                if (next_owner == OWN_DMA) begin
                    if (dma_any) begin
                        start_dma = 1'b1;
                    end else if (cpu_req) begin
                        start_cpu = 1'b1;
                    end
                end else begin
                    if (cpu_req) begin
                        start_cpu = 1'b1;
                    end else if (dma_any) begin
                        start_dma = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (start_dma) begin
            state_nxt     = ST_DMA;
            remaining_nxt = win_len;
        end
        if (start_cpu) begin
            state_nxt    = ST_CPU;
            hold_cnt_nxt = '0;
        end

        if (start_dma) begin
            io_sel_nxt = win_sel;
        end else if (state_nxt == ST_DMA) begin
            io_sel_nxt = io_sel;
        end else begin
            io_sel_nxt = SEL_INSTR;
        end
    end

    // State and registered outputs; reset aborts any burst without a done pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            next_owner    <= OWN_CPU;
            hold_cnt      <= '0;
            cpu_grant     <= 1'b0;
            grant         <= 1'b0;
            busybus       <= 1'b0;
            io_sel        <= SEL_INSTR;
            dma_remaining <= '0;
            dma_done      <= 1'b0;
        end else begin
            state         <= state_nxt;
            next_owner    <= next_owner_nxt;
            hold_cnt      <= hold_cnt_nxt;
            cpu_grant     <= (state_nxt == ST_CPU);
            grant         <= (state_nxt == ST_DMA);
            busybus       <= (state_nxt != ST_IDLE);
            io_sel        <= io_sel_nxt;
            dma_remaining <= remaining_nxt;
            dma_done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed scenarios with literal expectations,
// a behavioural ownership model compared every cycle, and a random phase.
module tb_bus_arbiter;

    localparam int unsigned MAXH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       cpu_req = 1'b0;
    logic       dma_req = 1'b0;
    logic [5:0] dma_count = '0;
    logic       IOIP1 = 1'b0;
    logic       IOIP2 = 1'b0;
    logic       cpu_grant;
    logic       grant;
    logic       busybus;
    logic [1:0] io_sel;
    logic [6:0] dma_remaining;
    logic       dma_done;

    bus_arbiter #(.MAX_CPU_HOLD(MAXH)) dut (
        .clock         (clock),
        .reset         (reset),
        .cpu_req       (cpu_req),
        .dma_req       (dma_req),
        .dma_count     (dma_count),
        .IOIP1         (IOIP1),
        .IOIP2         (IOIP2),
        .cpu_grant     (cpu_grant),
        .grant         (grant),
        .busybus       (busybus),
        .io_sel        (io_sel),
        .dma_remaining (dma_remaining),
        .dma_done      (dma_done)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit cpu;      // processor holds the bus
        bit dma;      // DMA holds the bus
        bit turn;     // dead cycle between owners
        bit to_dma;   // preferred owner after the dead cycle
        bit done;     // burst just finished
        int left;     // words left in burst
        int sel;      // grant reason
        int hold;     // cycles CPU has kept the bus with DMA waiting
    } model_t;

    function automatic model_t model_next(input model_t m, input bit creq, input bit dreq,
                                          input bit io1, input bit io2, input logic [5:0] cnt);
        model_t n = m;
        bit any_req = dreq | io1 | io2;
        bit go_dma = 0;
        bit go_cpu = 0;
        n.done = 0;
        if (m.dma) begin
            if (m.left == 1) begin
                n.done = 1; n.dma = 0; n.left = 0; n.sel = 0;
                if (creq) begin n.turn = 1; n.to_dma = 0; end
                else if (any_req) begin n.turn = 1; n.to_dma = 1; end
            end else begin
                n.left = m.left - 1;
            end
        end else if (m.cpu) begin
            n.hold = any_req ? m.hold + 1 : 0;
            if (!creq) begin
                n.cpu = 0; n.hold = 0;
                if (any_req) begin n.turn = 1; n.to_dma = 1; end
            end else if (n.hold == MAXH) begin
                n.cpu = 0; n.hold = 0; n.turn = 1; n.to_dma = 1;
            end
        end else if (m.turn) begin
            n.turn = 0;
            if (m.to_dma) begin
                if (any_req) go_dma = 1; else if (creq) go_cpu = 1;
            end else begin
                if (creq) go_cpu = 1; else if (any_req) go_dma = 1;
            end
        end else begin
            if (any_req) go_dma = 1; else if (creq) go_cpu = 1;
        end
        if (go_dma) begin
            n.dma  = 1;
            n.sel  = dreq ? 0 : (io1 ? 1 : 2);
            n.left = dreq ? ((cnt == 6'd0) ? 1 : int'(cnt)) : 1;
        end
        if (go_cpu) begin
            n.cpu = 1; n.hold = 0;
        end
        return n;
    endfunction

    model_t m_clear = '{default: 0};
    model_t m = '{default: 0};

    always @(posedge clock or posedge reset) begin
        if (reset) m <= m_clear;
        else       m <= model_next(m, cpu_req, dma_req, IOIP1, IOIP2, dma_count);
    end

    // ---------------- per-cycle compare ----------------
    logic pcg = 1'b0, pg = 1'b0, pbusy = 1'b0;
    int   turn_run = 0;

    always @(negedge clock) begin
        check("cmp.cpu_grant", cpu_grant, m.cpu);
        check("cmp.grant", grant, m.dma);
        check("cmp.busybus", busybus, m.cpu | m.dma | m.turn);
        check("cmp.io_sel", io_sel, m.sel);
        check("cmp.dma_remaining", dma_remaining, m.left);
        check("cmp.dma_done", dma_done, m.done);
        check("cmp.exclusive", cpu_grant & grant, 0);
        if ((cpu_grant && !pcg) || (grant && !pg)) begin
            check("cmp.handover_one_turn",
                  !pcg && !pg && (pbusy ? (turn_run == 1) : 1'b1), 1);
        end
        turn_run <= (busybus && !cpu_grant && !grant) ? turn_run + 1 : 0;
        pcg   <= cpu_grant;
        pg    <= grant;
        pbusy <= busybus;
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(negedge clock);
    endtask

    task automatic expect_out(input string tag, input logic cg, input logic g, input logic bb,
                              input logic [1:0] sel, input logic [6:0] rem, input logic done);
        check({tag, ".cpu_grant"}, cpu_grant, cg);
        check({tag, ".grant"}, grant, g);
        check({tag, ".busybus"}, busybus, bb);
        check({tag, ".io_sel"}, io_sel, sel);
        check({tag, ".dma_remaining"}, dma_remaining, rem);
        check({tag, ".dma_done"}, dma_done, done);
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) step();
        expect_out("reset", 0, 0, 0, 2'b00, 7'd0, 0);
        reset = 1'b0;
        step();
        expect_out("idle", 0, 0, 0, 2'b00, 7'd0, 0);

        // Lone instruction, count 5
        dma_req = 1; dma_count = 6'd5;
        step();
        expect_out("t1_first", 0, 1, 1, 2'b00, 7'd5, 0);
        dma_req = 0;
        for (int r = 4; r >= 1; r--) begin
            step();
            expect_out("t1_burst", 0, 1, 1, 2'b00, 7'(r), 0);
        end
        step();
        expect_out("t1_done", 0, 0, 0, 2'b00, 7'd0, 1);
        step();
        expect_out("t1_idle", 0, 0, 0, 2'b00, 7'd0, 0);

        // Everything at once from IDLE
        dma_req = 1; IOIP1 = 1; IOIP2 = 1; cpu_req = 1; dma_count = 6'd2;
        step();
        expect_out("t2_dma_a", 0, 1, 1, 2'b00, 7'd2, 0);
        dma_req = 0;
        step();
        expect_out("t2_dma_b", 0, 1, 1, 2'b00, 7'd1, 0);
        step();
        expect_out("t2_turn1", 0, 0, 1, 2'b00, 7'd0, 1);
        step();
        expect_out("t2_cpu", 1, 0, 1, 2'b00, 7'd0, 0);
        cpu_req = 0;
        step();
        expect_out("t2_turn2", 0, 0, 1, 2'b00, 7'd0, 0);
        step();
        expect_out("t2_io1", 0, 1, 1, 2'b01, 7'd1, 0);
        IOIP1 = 0;
        step();
        expect_out("t2_turn3", 0, 0, 1, 2'b00, 7'd0, 1);
        step();
        expect_out("t2_io2", 0, 1, 1, 2'b10, 7'd1, 0);
        IOIP2 = 0;
        step();
        expect_out("t2_done", 0, 0, 0, 2'b00, 7'd0, 1);
        step();
        expect_out("t2_idle", 0, 0, 0, 2'b00, 7'd0, 0);

        // Count zero, then count 63 with dma_req dropped mid-burst
        dma_req = 1; dma_count = 6'd0;
        step();
        expect_out("t3_zero", 0, 1, 1, 2'b00, 7'd1, 0);
        dma_req = 0;
        step();
        expect_out("t3_zero_done", 0, 0, 0, 2'b00, 7'd0, 1);
        dma_req = 1; dma_count = 6'd63;
        step();
        expect_out("t3_63_first", 0, 1, 1, 2'b00, 7'd63, 0);
        dma_count = 6'd7;
        for (int r = 62; r >= 1; r--) begin
            if (r == 61) dma_req = 0;
            step();
            expect_out("t3_63_burst", 0, 1, 1, 2'b00, 7'(r), 0);
        end
        step();
        expect_out("t3_63_done", 0, 0, 0, 2'b00, 7'd0, 1);
        step();
        expect_out("t3_idle", 0, 0, 0, 2'b00, 7'd0, 0);

        // CPU starvation bound (MAX_CPU_HOLD = 4)
        cpu_req = 1;
        step();
        expect_out("t4_cpu_entry", 1, 0, 1, 2'b00, 7'd0, 0);
        step();
        expect_out("t4_cpu_1", 1, 0, 1, 2'b00, 7'd0, 0);
        IOIP2 = 1;
        repeat (3) begin
            step();
            expect_out("t4_cpu_hold", 1, 0, 1, 2'b00, 7'd0, 0);
        end
        step();
        expect_out("t4_preempt_turn", 0, 0, 1, 2'b00, 7'd0, 0);
        step();
        expect_out("t4_io2", 0, 1, 1, 2'b10, 7'd1, 0);
        IOIP2 = 0;
        step();
        expect_out("t4_turn_back", 0, 0, 1, 2'b00, 7'd0, 1);
        step();
        expect_out("t4_cpu_again", 1, 0, 1, 2'b00, 7'd0, 0);
        cpu_req = 0;
        step();
        expect_out("t4_idle", 0, 0, 0, 2'b00, 7'd0, 0);

        // Asynchronous reset in burst cycle 4
        dma_req = 1; dma_count = 6'd10;
        for (int r = 10; r >= 7; r--) begin
            step();
            expect_out("t5_burst", 0, 1, 1, 2'b00, 7'(r), 0);
        end
        #2 reset = 1'b1;
        #1 expect_out("t5_async", 0, 0, 0, 2'b00, 7'd0, 0);
        step();
        expect_out("t5_in_reset", 0, 0, 0, 2'b00, 7'd0, 0);
        reset = 1'b0;
        step();
        expect_out("t5_restart", 0, 1, 1, 2'b00, 7'd10, 0);
        dma_req = 0;
        for (int r = 9; r >= 1; r--) begin
            step();
            expect_out("t5_reburst", 0, 1, 1, 2'b00, 7'(r), 0);
        end
        step();
        expect_out("t5_done", 0, 0, 0, 2'b00, 7'd0, 1);

        // Random phase: model and invariant checks run every cycle
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) cpu_req = ~cpu_req;
            dma_req   = ($urandom_range(0, 9) == 0);
            IOIP1     = ($urandom_range(0, 11) == 0);
            IOIP2     = ($urandom_range(0, 11) == 0);
            dma_count = 6'($urandom_range(0, 7));
            step();
        end
        cpu_req = 0; dma_req = 0; IOIP1 = 0; IOIP2 = 0;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
